// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller driving CPU HWInt[7:2].
// Optional macro INT_CTRL_PRIO_EN makes HWInt one-hot (lowest index wins).
//
// Ports:
//   Clock, Reset    - system clock, synchronous active-high reset
//   IRQ[5:0]        - device interrupt lines (Clock domain)
//   Addr[1:0]       - register select: 0 PEND, 1 MASK, 2 MODE, 3 STATUS
//   WE, WD[31:0]    - single-cycle write strobe and data (WD[5:0] used)
//   RD[31:0]        - combinational read data for Addr
//   HWInt[5:0]      - registered interrupt vector
module int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [NSRC-1:0] IRQ,
  input  logic [1:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     WD,
  output logic [31:0]     RD,
  output logic [NSRC-1:0] HWInt
);

  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] hw_nxt;
  logic [2:0]      idx;
  logic            any;
  logic            wd_unused;

  assign wd_unused = ^WD[31:NSRC];

  assign rise = IRQ & ~irq_q;
  assign clr  = (WE && Addr == 2'd0) ? WD[NSRC-1:0] : '0;

  // Level bits track IRQ; edge bits set on rise, else clear on write.
  // A rise beats a same-cycle clear so no edge is lost.
  assign pend_nxt = (~mode & IRQ)
                  | (mode & (rise | (pend & ~clr)));

  assign act = pend & mask;
  assign any = |act;

  always_comb begin
    idx = 3'd7;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) idx = i[2:0];
    end
  end

`ifdef INT_CTRL_PRIO_EN
  // Isolate lowest set bit: matches the STATUS index.
  assign hw_nxt = act & (-act);
`else
  assign hw_nxt = act;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      HWInt <= '0;
    end else begin
      irq_q <= IRQ;
      pend  <= pend_nxt;
      HWInt <= hw_nxt;
      if (WE && Addr == 2'd1) mask <= WD[NSRC-1:0];
      if (WE && Addr == 2'd2) mode <= WD[NSRC-1:0];
    end
  end

  always_comb begin
    RD = '0;
    case (Addr)
      2'd0: RD = {{(32-NSRC){1'b0}}, pend};
      2'd1: RD = {{(32-NSRC){1'b0}}, mask};
      2'd2: RD = {{(32-NSRC){1'b0}}, mode};
      2'd3: RD = {any, 28'b0, idx};
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed plan steps plus random traffic against a
// per-source behavioural model of the interrupt controller.
module tb_int_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [5:0]  IRQ;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [5:0]  HWInt;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] m_prev = '0;
  logic [5:0] m_pend = '0;
  logic [5:0] m_mask = '0;
  logic [5:0] m_mode = '0;
  logic [5:0] m_hw   = '0;

  always #5 Clock = ~Clock;

  int_ctrl #(.NSRC(6)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .IRQ(IRQ),
    .Addr(Addr),
    .WE(WE),
    .WD(WD),
    .RD(RD),
    .HWInt(HWInt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 7;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    int k;
    case (a)
      2'd0: return {26'b0, m_pend};
      2'd1: return {26'b0, m_mask};
      2'd2: return {26'b0, m_mode};
      default: begin
        k = lowest(m_pend & m_mask);
        return {k != 7, 28'b0, 3'(k)};
      end
    endcase
  endfunction

  // Advance the model by one clock using the inputs seen at the edge.
  task automatic model_update();
    logic [5:0] np;
    int k;
    if (Reset) begin
      m_prev = '0; m_pend = '0; m_mask = '0; m_mode = '0; m_hw = '0;
      return;
    end
    np = m_pend;
    for (int i = 0; i < 6; i++) begin
      if (!m_mode[i])
        np[i] = IRQ[i];
      else if (IRQ[i] && !m_prev[i])
        np[i] = 1'b1;
      else if (WE && Addr == 2'd0 && WD[i])
        np[i] = 1'b0;
    end
`ifdef INT_CTRL_PRIO_EN
    k = lowest(m_pend & m_mask);
    m_hw = (k == 7) ? 6'd0 : 6'(1 << k);
`else
    k = 0;
    m_hw = m_pend & m_mask;
`endif
    if (WE && Addr == 2'd1) m_mask = WD[5:0];
    if (WE && Addr == 2'd2) m_mode = WD[5:0];
    m_pend = np;
    m_prev = IRQ;
  endtask

  task automatic step();
    @(posedge Clock);
    model_update();
    #1;
    chk("hwint", {26'b0, HWInt}, {26'b0, m_hw});
  endtask

  task automatic cyc(input logic r, input logic [5:0] irq,
                     input logic we, input logic [1:0] a,
                     input logic [31:0] wd);
    Reset = r; IRQ = irq; WE = we; Addr = a; WD = wd;
    step();
    Reset = 1'b0; WE = 1'b0;
  endtask

  task automatic rdexp(input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk("rd_dir", RD, exp);
    chk("rd_mdl", RD, model_rd(a));
  endtask

  initial begin
    int cnt;
    logic [1:0] ra;
    Reset = 1'b1; IRQ = '0; WE = 1'b0; Addr = '0; WD = '0;

    // 1: reset values
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    rdexp(0, 0); rdexp(1, 0); rdexp(2, 0); rdexp(3, 32'h7);
    chk("rst_hw", {26'b0, HWInt}, 0);

    // 2: edge pulse, latency, clear
    cyc(0, 0, 1, 2, 32'h3F);
    cyc(0, 0, 1, 1, 32'h3F);
    cyc(0, 6'h04, 0, 0, 0);
    rdexp(0, 32'h04);
    cyc(0, 0, 0, 0, 0);
    chk("t2_hw", {26'b0, HWInt}, 32'h04);
    cyc(0, 0, 1, 0, 32'h04);
    cyc(0, 0, 0, 0, 0);
    chk("t2_clr", {26'b0, HWInt}, 0);

    // 3: rise beats clear; held high sets once
    cyc(0, 6'h02, 1, 0, 32'h02);
    rdexp(0, 32'h02);
    cyc(0, 6'h02, 1, 0, 32'h02);
    rdexp(0, 32'h00);
    cyc(0, 0, 0, 0, 0);

    // 4: level mode, 5-cycle hold, clear ignored
    cyc(0, 0, 1, 2, 32'h00);
    cyc(0, 0, 1, 1, 32'h01);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(0, (c < 5) ? 6'h01 : 6'h00, c == 2, 0, 32'h01);
      if (HWInt[0]) cnt++;
      if (c == 0) chk("t4_lat0", {31'b0, HWInt[0]}, 0);
      if (c == 1) chk("t4_lat1", {31'b0, HWInt[0]}, 1);
    end
    chk("t4_cnt", cnt, 5);

    // 5: two sources together
    cyc(0, 0, 1, 2, 32'h3F);
    cyc(0, 0, 1, 1, 32'h30);
    cyc(0, 6'h30, 0, 0, 0);
    rdexp(3, 32'h80000004);
    cyc(0, 0, 0, 0, 0);
`ifdef INT_CTRL_PRIO_EN
    chk("t5_hw", {26'b0, HWInt}, 32'h10);
`else
    chk("t5_hw", {26'b0, HWInt}, 32'h30);
`endif
    cyc(0, 0, 1, 0, 32'h10);
    cyc(0, 0, 0, 0, 0);
    chk("t5_hw2", {26'b0, HWInt}, 32'h20);

    // 6: reset beats write and edge
    cyc(1, 6'h01, 1, 1, 32'h3F);
    rdexp(0, 0); rdexp(1, 0); rdexp(2, 0); rdexp(3, 32'h7);
    chk("t6_hw", {26'b0, HWInt}, 0);
    cyc(0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 99) == 0,
          IRQ ^ 6'($urandom & $urandom),
          $urandom_range(0, 3) == 0,
          2'($urandom),
          $urandom);
      ra = 2'($urandom);
      Addr = ra;
      #1;
      chk("rnd_rd", RD, model_rd(ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller sitting on the processor's peripheral bus, between the device set (timers, UART, switches) and the `HWInt[7:2]` input of `CPU`. It collects six device interrupt lines, holds edge-triggered requests as sticky pending bits, applies a software mask, and drives a registered `HWInt` vector. The CPU programs and services it through memory-mapped registers over the same bridge bus that carries `PrAddr`, `PrWd` and `PrRd`.

## Interface

Parameters:
- `NSRC`, default 6: number of interrupt sources. Fixed at 6 to match `HWInt[7:2]`; other values are unsupported.

Ports:
- `Clock` in 1: single system clock. All state changes on the rising edge.
- `Reset` in 1: synchronous, active-high. Sampled on the rising edge of `Clock`.
- `IRQ` in 6: device interrupt lines, same clock domain as `Clock`. Bit i is source i.
- `Addr` in 2: word offset within the block, bridge address bits [3:2].
- `WE` in 1: write strobe from the bridge, valid for one cycle.
- `WD` in 32: write data. Bits [5:0] are used; higher bits are ignored.
- `RD` out 32: read data, combinational from `Addr`. Bits [31:6] always read 0, except in STATUS.
- `HWInt` out 6: registered interrupt vector to the `CPU` `HWInt[7:2]` input.

## Operation

Register map (`Addr`):
- 0 PEND:
  - Read: the pending bits.
  - Write: a 1 in bit i clears PEND[i] if source i is in edge mode. Writes to level-mode bits are ignored.
- 1 MASK: read/write. A 1 enables the source.
- 2 MODE: read/write. 1 selects edge mode, 0 selects level mode.
  - Changing a bit from edge to level makes PEND[i] follow `IRQ[i]` from the next edge.
  - Changing a bit from level to edge keeps PEND[i] as is.
- 3 STATUS: read-only; writes are ignored.
  - Bit 31: any masked pending bit is set.
  - Bits [2:0]: index of the lowest-numbered masked pending source. Source 0 has the highest priority.
  - Bits [2:0] read 7 when nothing is masked and pending.

Internal state: `IRQ_q` (previous `IRQ`), PEND, MASK and MODE, each 6 bits.

PEND update per bit, each clock edge:
- Level mode: PEND[i] <= `IRQ[i]`.
- Edge mode, set: if `IRQ[i] & ~IRQ_q[i]`, PEND[i] <= 1.
- Edge mode, clear: else if a PEND write has `WD[i]`=1, PEND[i] <= 0.
- Edge mode, otherwise PEND[i] holds.
- A set and a clear in the same cycle: set wins, so a new edge is never lost.

Output: `HWInt` <= PEND & MASK, unless `INT_CTRL_PRIO_EN` applies (see Configuration).

Reset: `IRQ_q`, PEND, MASK, MODE and `HWInt` all clear to 0. After reset, all sources are level mode and masked.
- `RD` follows the reset register values; STATUS reads 0x00000007.
- Reset has priority over a simultaneous `WE` or IRQ edge. Any pending edge is discarded.

## Timing

- IRQ to PEND: an edge present before edge k (`IRQ` high, `IRQ_q` low) sets PEND at edge k.
- PEND to `HWInt`: `HWInt` asserts at edge k+1. IRQ-to-`HWInt` latency is 2 cycles; level mode is the same.
- Writes take effect at the clock edge that samples `WE`=1. `HWInt` reflects the write one edge later.
  - Example: a PEND clear at edge k drops `HWInt` at edge k+1.
- Reads: `RD` is combinational, zero-wait, and shows register state after the most recent edge.
- Holding `IRQ` high in edge mode produces exactly one set. A new set requires a low cycle on `IRQ` first.

## Configuration

Macro `INT_CTRL_PRIO_EN`:
- Defined: `HWInt` is one-hot. Only the bit at the STATUS index is driven (lowest-numbered masked pending source), or all zero when nothing is pending. Latency is unchanged.
- Undefined: `HWInt` = PEND & MASK, so several bits may assert together. STATUS still reads as specified.

## Test plan

1. Reset, read all four offsets -> 0, 0, 0, 0x00000007; `HWInt`=0.
2. MODE=0x3F, MASK=0x3F, then pulse `IRQ[2]` high for 1 cycle at edge k -> PEND=0x04 at k; `HWInt`=0x04 at k+1. Write PEND=0x04 at edge m -> `HWInt`=0 at m+1.
3. Edge mode: write PEND clear of bit 1 in the same cycle as a rising `IRQ[1]` -> PEND[1] stays 1.
4. Level mode, MASK=0x01: hold `IRQ[0]` high 5 cycles, then low -> `HWInt[0]` high for exactly 5 cycles, delayed 2 cycles from `IRQ`. Write PEND=0x01 while high -> no effect.
5. MASK=0x30, edges on `IRQ[5]` and `IRQ[4]` together -> STATUS=0x80000004.
   - Without the macro: `HWInt`=0x30.
   - With `INT_CTRL_PRIO_EN`: `HWInt`=0x10; clear bit 4 -> `HWInt`=0x20 next cycle.
6. Set PEND/MASK non-zero, assert `Reset` for 1 cycle together with `WE` and an IRQ edge -> all registers 0 and `HWInt`=0 after that edge.
